// File: rtl/stopwatch_timer_pkg.sv
// Shared types and constants for the MM:SS stopwatch / countdown timer.
//   bcd_t        : one BCD digit (4 bits)
//   SEC_TENS_MAX : highest legal seconds-tens digit
//   DIGIT_MAX    : highest legal value for every other digit
//   mode_e       : count up (stopwatch) or count down (timer)
//   clamp_digit  : limits a preset digit to its legal maximum
package stopwatch_timer_pkg;

    typedef logic [3:0] bcd_t;

    localparam bcd_t SEC_TENS_MAX = 4'd5;
    localparam bcd_t DIGIT_MAX    = 4'd9;

    typedef enum logic {
        MODE_STOPWATCH = 1'b0,
        MODE_TIMER     = 1'b1
    } mode_e;

    function automatic bcd_t clamp_digit(input bcd_t d, input bcd_t max);
        return (d > max) ? max : d;
    endfunction

endpackage

// File: rtl/stopwatch_timer_bcd_digit_counter.sv
// One BCD digit of a chained up/down counter.
//   MAX      : modulo-max value of this digit (wraps MAX->0 up, 0->MAX down)
//   clk, rst : clock, asynchronous active-high reset (digit -> 0)
//   en       : advance this digit on the edge
//   up       : 1 = increment, 0 = decrement
//   load     : preset from load_val (overrides en)
//   load_val : preset value, already clamped by the caller
//   q        : current digit
//   co       : carry (up, q==MAX) or borrow (down, q==0) while enabled;
//              drives the next digit's enable in the chain
module bcd_digit_counter
    import stopwatch_timer_pkg::*;
#(
    parameter bcd_t MAX = DIGIT_MAX
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic up,
    input  logic load,
    input  bcd_t load_val,
    output bcd_t q,
    output logic co
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            if (up) begin
                q <= (q == MAX) ? '0 : q + 4'd1;
            end else begin
                q <= (q == '0) ? MAX : q - 4'd1;
            end
        end
    end

    assign co = en && (up ? (q == MAX) : (q == '0));

endmodule

// File: rtl/stopwatch_timer.sv
// MM:SS stopwatch / countdown timer with a 1 s prescaler.
//   CLK_FREQ       : clock cycles per second (>= 1)
//   clk, rst       : clock, asynchronous active-high reset
//   start          : level, 1 = count, 0 = pause (digits and prescaler hold)
//   load           : preset strobe; loads clamped digits and selects timer mode
//   load_*         : preset digits (BCD)
//   min_*, sec_*   : registered time digits
//   done           : registered, sticky countdown-expired flag
// Edge priority is rst > load > count. Once done is set, counting stops
// and the digits hold 00:00 until the next load or reset.
module stopwatch_timer
    import stopwatch_timer_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       load,
    input  logic [3:0] load_min_ones,
    input  logic [3:0] load_min_tens,
    input  logic [3:0] load_sec_ones,
    input  logic [3:0] load_sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic       done
);

    // A one-bit prescaler is kept even for CLK_FREQ == 1, where it stays 0.
    localparam int             PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0]  TC = PW'(CLK_FREQ - 1);

    logic [PW-1:0] presc_q, presc_d;
    mode_e         mode_q, mode_d;
    logic          done_q, done_d;

    logic count_en, tick, all_zero, at_one, digit_en, up;
    logic so_co, st_co, mo_co, unused_wrap;

    always_comb begin
        count_en = start && !done_q;
        tick     = count_en && (presc_q == TC);
        all_zero = (min_tens == '0) && (min_ones == '0) &&
                   (sec_tens == '0) && (sec_ones == '0);
        at_one   = (min_tens == '0) && (min_ones == '0) &&
                   (sec_tens == '0) && (sec_ones == 4'd1);
        up       = (mode_q == MODE_STOPWATCH);
        // A timer preset of 00:00 must not underflow: the tick only raises done.
        digit_en = tick && !((mode_q == MODE_TIMER) && all_zero);

        presc_d = presc_q;
        mode_d  = mode_q;
        done_d  = done_q;
        if (load) begin
            presc_d = '0;
            mode_d  = MODE_TIMER;
            done_d  = 1'b0;
        end else if (count_en) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
            if (tick && (mode_q == MODE_TIMER) && (all_zero || at_one)) begin
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            mode_q  <= MODE_STOPWATCH;
            done_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign done = done_q;

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_sec_ones (
        .clk      (clk),
        .rst      (rst),
        .en       (digit_en),
        .up       (up),
        .load     (load),
        .load_val (clamp_digit(load_sec_ones, DIGIT_MAX)),
        .q        (sec_ones),
        .co       (so_co)
    );

    bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
        .clk      (clk),
        .rst      (rst),
        .en       (so_co),
        .up       (up),
        .load     (load),
        .load_val (clamp_digit(load_sec_tens, SEC_TENS_MAX)),
        .q        (sec_tens),
        .co       (st_co)
    );

    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_min_ones (
        .clk      (clk),
        .rst      (rst),
        .en       (st_co),
        .up       (up),
        .load     (load),
        .load_val (clamp_digit(load_min_ones, DIGIT_MAX)),
        .q        (min_ones),
        .co       (mo_co)
    );

    // The top digit's carry only marks the 99:59 -> 00:00 wrap; nothing needs it.
    bcd_digit_counter #(.MAX(DIGIT_MAX)) u_min_tens (
        .clk      (clk),
        .rst      (rst),
        .en       (mo_co),
        .up       (up),
        .load     (load),
        .load_val (clamp_digit(load_min_tens, DIGIT_MAX)),
        .q        (min_tens),
        .co       (unused_wrap)
    );

endmodule

// File: tb/tb_stopwatch_timer.sv
module tb_stopwatch_timer;

  localparam int CF = 10;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       start = 1'b0;
  logic       load = 1'b0;
  logic [3:0] l_mo = '0, l_mt = '0, l_so = '0, l_st = '0;
  logic [3:0] min_ones, min_tens, sec_ones, sec_tens;
  logic       done;

  stopwatch_timer #(.CLK_FREQ(CF)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .load          (load),
    .load_min_ones (l_mo),
    .load_min_tens (l_mt),
    .load_sec_ones (l_so),
    .load_sec_tens (l_st),
    .min_ones      (min_ones),
    .min_tens      (min_tens),
    .sec_ones      (sec_ones),
    .sec_tens      (sec_tens),
    .done          (done)
  );

  // observed view: {MM:SS as 16 BCD bits, done}
  wire [16:0] dut_v = {min_tens, min_ones, sec_tens, sec_ones, done};

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [16:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model (time as plain seconds) ----------------
  int m_secs, m_presc;
  bit m_timer, m_done;

  function automatic int cl(input int d, input int max);
    return (d > max) ? max : d;
  endfunction

  function automatic logic [16:0] model_view();
    int mins, secs;
    mins = m_secs / 60;
    secs = m_secs % 60;
    return {4'(mins / 10), 4'(mins % 10), 4'(secs / 10), 4'(secs % 10), m_done};
  endfunction

  task automatic model_reset();
    m_secs = 0; m_presc = 0; m_timer = 0; m_done = 0;
  endtask

  task automatic model_edge();
    bit t;
    t = 0;
    if (rst) begin
      model_reset();
    end else if (load) begin
      m_secs  = cl(l_mt, 9) * 600 + cl(l_mo, 9) * 60 + cl(l_st, 5) * 10 + cl(l_so, 9);
      m_presc = 0;
      m_done  = 0;
      m_timer = 1;
    end else if (start && !m_done) begin
      if (m_presc == CF - 1) begin
        m_presc = 0;
        t = 1;
      end else begin
        m_presc++;
      end
    end
    if (t) begin
      if (!m_timer) begin
        m_secs = (m_secs + 1) % 6000;
      end else if (m_secs <= 1) begin
        m_secs = 0;
        m_done = 1;
      end else begin
        m_secs--;
      end
    end
    exp_q.push_back(model_view());
  endtask

  // ---------------- driver tasks ----------------
  // One clock edge: model sees the inputs present at the edge, DUT sampled 1 ns later.
  task automatic step(input string tag);
    logic [16:0] e;
    @(posedge clk);
    model_edge();
    #1;
    e = exp_q.pop_front();
    chk(tag, dut_v, e);
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst", dut_v, 17'h0);
    step("rst_edge");
    rst = 1'b0;
  endtask

  task automatic do_load(input int mt, input int mo, input int st, input int so, input bit st_in);
    l_mt = 4'(mt); l_mo = 4'(mo); l_st = 4'(st); l_so = 4'(so);
    load = 1'b1;
    start = st_in;
    step("load_edge");
    load = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    chk("reset_state", dut_v, 17'h0);

    // stopwatch from reset
    start = 1'b1;
    for (int i = 1; i <= 30; i++) begin
      step("sw_run");
      if (i == 9)  chk("sw_no_tick_yet", dut_v, {16'h0000, 1'b0});
      if (i == 10) chk("sw_first_tick", dut_v, {16'h0001, 1'b0});
    end
    chk("sw_30_edges", dut_v, {16'h0003, 1'b0});

    // pause keeps the partial second
    start = 1'b0;
    do_reset();
    start = 1'b1;
    run(15, "pause_pre");
    chk("pause_pre", dut_v, {16'h0001, 1'b0});
    start = 1'b0;
    run(40, "paused");
    chk("paused_hold", dut_v, {16'h0001, 1'b0});
    start = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step("resume");
      if (i == 4) chk("resume_4", dut_v, {16'h0001, 1'b0});
    end
    chk("resume_5", dut_v, {16'h0002, 1'b0});

    // countdown from 00:05
    do_load(0, 0, 0, 5, 1'b0);
    chk("load_0005", dut_v, {16'h0005, 1'b0});
    start = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      step("countdown");
      if (i == 10) chk("cd_0004", dut_v, {16'h0004, 1'b0});
      if (i == 49) chk("cd_edge49", dut_v, {16'h0001, 1'b0});
    end
    chk("cd_done_50", dut_v, {16'h0000, 1'b1});
    run(15, "done_hold");
    chk("done_sticky", dut_v, {16'h0000, 1'b1});

    // clamp, load beats start, done cleared
    do_load(9, 9, 7, 12, 1'b1);
    chk("clamp_9959", dut_v, {16'h9959, 1'b0});
    for (int i = 1; i <= 10; i++) begin
      step("clamp_run");
      if (i == 9) chk("clamp_presc_clear", dut_v, {16'h9959, 1'b0});
    end
    chk("clamp_tick", dut_v, {16'h9958, 1'b0});

    // minute borrow
    do_load(1, 0, 0, 0, 1'b0);
    start = 1'b1;
    run(10, "borrow");
    chk("borrow_0959", dut_v, {16'h0959, 1'b0});

    // preset 00:00 expires without underflow
    do_load(0, 0, 0, 0, 1'b0);
    start = 1'b1;
    run(10, "zero_preset");
    chk("zero_preset_done", dut_v, {16'h0000, 1'b1});

    // async reset mid-countdown returns to stopwatch
    do_load(0, 0, 3, 0, 1'b0);
    start = 1'b1;
    run(25, "cd_mid");
    chk("cd_mid_0028", dut_v, {16'h0028, 1'b0});
    do_reset();
    run(20, "after_rst");
    chk("after_rst_up", dut_v, {16'h0002, 1'b0});

    // randomized mix
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else if ($urandom_range(0, 59) == 0) begin
        l_mt = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(0, 15));
        l_mo = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(0, 15));
        l_st = ($urandom_range(0, 1) != 0) ? 4'd0 : 4'($urandom_range(0, 15));
        l_so = 4'($urandom_range(0, 15));
        load = 1'b1;
        step("rand_load");
        load = 1'b0;
      end else begin
        step("rand");
      end
    end

    // full stopwatch wrap
    start = 1'b0;
    do_reset();
    start = 1'b1;
    for (int k = 1; k <= 6000; k++) begin
      run(CF, "long");
      if (k == 59)   chk("long_0059", dut_v, {16'h0059, 1'b0});
      if (k == 60)   chk("long_0100", dut_v, {16'h0100, 1'b0});
      if (k == 5999) chk("long_9959", dut_v, {16'h9959, 1'b0});
      if (k == 6000) chk("long_wrap", dut_v, {16'h0000, 1'b0});
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
